// File: rtl/lif_pkg.sv
// lif_pkg: shared fp16 constants, FSM state type and fp16 arithmetic helpers
// Helpers convert fp16 to an exact signed fixed-point value in units of 2^-24.
// Results are truncated toward zero, and subnormals are supported.
// Overflow saturates to infinity.
package lif_pkg;
  typedef enum logic {RUN, EMIT} state_t;
  localparam logic [15:0] FP_ONE  = 16'h3C00;
  localparam logic [15:0] FP_HALF = 16'h3800;
  localparam logic [15:0] FP_0P95 = 16'h3B99;
  function automatic logic signed [42:0] to_sfix(input logic [15:0] f);
    logic [4:0] e;
    logic [42:0] m;
    e = f[14:10];
    m = {32'd0, e != 5'd0, f[9:0]} << (e == 5'd0 ? 5'd0 : e - 5'd1);
    return f[15] ? -m : m;
  endfunction
  function automatic logic [15:0] from_fix(input logic s, input logic [57:0] x);
    int p;
    logic [57:0] y;
    p = 0;
    for (int i = 10; i < 58; i++) if (x[i]) p = i - 9;
    y = x >> (p == 0 ? 0 : p - 1);
    return x == 58'd0 ? 16'h0000 : p > 30 ? {s, 15'h7C00} : {s, 5'(p), y[9:0]};
  endfunction
  function automatic logic [15:0] float_mult(input logic [15:0] a, input logic [15:0] b);
    logic [85:0] p;
    p = 86'(to_sfix({1'b0, a[14:0]})) * 86'(to_sfix({1'b0, b[14:0]}));
    return from_fix(a[15] ^ b[15], 58'(p >> 24));
  endfunction
  function automatic logic [15:0] float_add(input logic [15:0] a, input logic [15:0] b);
    logic signed [42:0] s;
    logic [41:0] m;
    s = to_sfix(a) + to_sfix(b);
    m = 42'(s[42] ? -s : s);
    return from_fix(s[42], {16'd0, m});
  endfunction
  function automatic logic float_compare_gt(input logic [15:0] a, input logic [15:0] b);
    return to_sfix(a) > to_sfix(b);
  endfunction
endpackage

// File: rtl/lif_neuron_array_core.sv
// lif_update_core: combinational per-beat LIF update for one neuron
// Inputs:  v, th, r (neuron state), current, adapt_en
// Outputs: v_next, th_next, r_next, fire
module lif_update_core
  import lif_pkg::*;
#(
  parameter int REFRACT_STEPS = 2,
  parameter logic [15:0] THRESH_INIT = FP_ONE,
  parameter logic [15:0] LEAK = FP_HALF,
  parameter logic [15:0] DELTA_TH = FP_HALF,
  parameter logic [15:0] TH_DECAY = FP_0P95
) (
  input  logic [15:0] v,
  input  logic [15:0] th,
  input  logic [3:0]  r,
  input  logic [15:0] current,
  input  logic        adapt_en,
  output logic [15:0] v_next,
  output logic [15:0] th_next,
  output logic [3:0]  r_next,
  output logic        fire
);
  logic [15:0] v_int, th_dec;
  logic refr;
  always_comb begin
    refr = r != 4'd0;
    v_int = float_add(float_mult(v, LEAK), current);
    fire = !refr && float_compare_gt(v_int, th);
    th_dec = float_mult(th, TH_DECAY);
    v_next = (refr || fire) ? 16'h0000 : v_int;
    r_next = refr ? r - 4'd1 : fire ? 4'(REFRACT_STEPS) : 4'd0;
    th_next = !adapt_en ? THRESH_INIT : fire ? float_add(th, DELTA_TH) :
              float_compare_gt(th_dec, THRESH_INIT) ? th_dec : THRESH_INIT;
  end
endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed array of leaky integrate-and-fire neurons
// clk/reset (async, active-low), clear (sync), adapt_en selects adaptive threshold.
// in_valid/in_ready/in_current: one fp16 current beat per neuron, index 0..N-1.
// spike_valid/spike_ready/spike_vec: per-timestep spike vector handshake.
// step_count: completed timesteps.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 16,
  parameter int REFRACT_STEPS = 2,
  parameter logic [15:0] THRESH_INIT = FP_ONE,
  parameter logic [15:0] LEAK = FP_HALF,
  parameter logic [15:0] DELTA_TH = FP_HALF,
  parameter logic [15:0] TH_DECAY = FP_0P95
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 adapt_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_current,
  output logic                 spike_valid,
  input  logic                 spike_ready,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic [15:0]          step_count
);
  localparam int IW = $clog2(N_NEURONS);
  state_t state, state_n;
  logic [15:0] v [N_NEURONS];
  logic [15:0] th [N_NEURONS];
  logic [3:0] r [N_NEURONS];
  logic [IW-1:0] idx;
  logic [15:0] v_n, th_n;
  logic [3:0] r_n;
  logic fire, acc, last;
  lif_update_core #(
    .REFRACT_STEPS(REFRACT_STEPS), .THRESH_INIT(THRESH_INIT),
    .LEAK(LEAK), .DELTA_TH(DELTA_TH), .TH_DECAY(TH_DECAY)
  ) u_core (
    .v(v[idx]), .th(th[idx]), .r(r[idx]), .current(in_current), .adapt_en(adapt_en),
    .v_next(v_n), .th_next(th_n), .r_next(r_n), .fire(fire)
  );
  assign in_ready = state == RUN;
  assign spike_valid = state == EMIT;
  assign acc = in_valid && in_ready;
  assign last = idx == IW'(N_NEURONS - 1);
  always_comb begin
    state_n = state;
    if (state == RUN && acc && last) state_n = EMIT;
    if (state == EMIT && spike_ready) state_n = RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      idx <= '0;
      spike_vec <= '0;
      step_count <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i] <= '0;
        th[i] <= THRESH_INIT;
        r[i] <= '0;
      end
    end else if (clear) begin
      state <= RUN;
      idx <= '0;
      spike_vec <= '0;
      step_count <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i] <= '0;
        th[i] <= THRESH_INIT;
        r[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (acc) begin
        idx <= last ? '0 : idx + 1'b1;
        v[idx] <= v_n;
        th[idx] <= th_n;
        r[idx] <= r_n;
        spike_vec[idx] <= fire;
      end
      if (spike_valid && spike_ready) step_count <= step_count + 16'd1;
    end
endmodule
